// File: rtl/cci_mpf_prim_rmw_pkg.sv
// Shared types and the per-lane operation for the read-modify-write pipeline.
package cci_mpf_prim_rmw_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    ADD   = 2'd2,
    OR    = 2'd3
  } t_rmw_op;

  // Lanes are zero-extended to this width; callers truncate the result back.
  localparam int MAX_LANE_BITS = 64;

  function automatic logic [MAX_LANE_BITS-1:0] rmw_lane_apply(
    input t_rmw_op                  op,
    input logic [MAX_LANE_BITS-1:0] old_v,
    input logic [MAX_LANE_BITS-1:0] opnd
  );
    case (op)
      WRITE:   return opnd;
      ADD:     return old_v + opnd;
      OR:      return old_v | opnd;
      default: return old_v;
    endcase
  endfunction

endpackage

// File: rtl/cci_mpf_prim_ram_rmw_pipe_fwd_history.sv
// L-entry history of recent commits; patches stale RAM read data oldest to youngest.
module cci_mpf_prim_rmw_fwd_history
  import cci_mpf_prim_rmw_pkg::*;
#(
  parameter int L  = 1,
  parameter int AW = 5,
  parameter int NB = 8,
  parameter int BB = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push_valid,
  input  logic [AW-1:0]    i_push_addr,
  input  logic [NB-1:0]    i_push_byteena,
  input  logic [NB*BB-1:0] i_push_data,
  input  logic [AW-1:0]    i_lookup_addr,
  input  logic [NB*BB-1:0] i_lookup_rdata,
  output logic [NB*BB-1:0] o_patched_data
);

  // Entry 0 is the youngest commit (previous cycle), entry L-1 the oldest.
  logic [L-1:0]     r_hist_valid;
  logic [AW-1:0]    r_hist_addr [L];
  logic [NB-1:0]    r_hist_be   [L];
  logic [NB*BB-1:0] r_hist_data [L];
  logic [NB*BB-1:0] w_patched;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist_valid <= '0;
    end else begin
      for (int i = L - 1; i > 0; i--) r_hist_valid[i] <= r_hist_valid[i-1];
      r_hist_valid[0] <= i_push_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = L - 1; i > 0; i--) begin
      r_hist_addr[i] <= r_hist_addr[i-1];
      r_hist_be[i]   <= r_hist_be[i-1];
      r_hist_data[i] <= r_hist_data[i-1];
    end
    r_hist_addr[0] <= i_push_addr;
    r_hist_be[0]   <= i_push_byteena;
    r_hist_data[0] <= i_push_data;
  end

  always_comb begin
    w_patched = i_lookup_rdata;
    for (int i = L - 1; i >= 0; i--) begin
      if (r_hist_valid[i] && (r_hist_addr[i] == i_lookup_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (r_hist_be[i][b]) w_patched[b*BB +: BB] = r_hist_data[i][b*BB +: BB];
        end
      end
    end
  end

  assign o_patched_data = w_patched;

endmodule

// File: rtl/cci_mpf_prim_ram_rmw_pipe.sv
// Fetch-and-op front end for a dual-port byte-enable RAM: read on port 1, commit on port 0.
module cci_mpf_prim_ram_rmw_pipe
  import cci_mpf_prim_rmw_pkg::*;
#(
  parameter int N_ENTRIES      = 32,
  parameter int N_DATA_BITS    = 64,
  parameter int N_BYTE_BITS    = 8,
  parameter int RAM_RD_LATENCY = 1,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int NB = N_DATA_BITS / N_BYTE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ram_rdy,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [1:0]             in_op,
  input  logic [AW-1:0]          in_addr,
  input  logic [NB-1:0]          in_byteena,
  input  logic [N_DATA_BITS-1:0] in_data,
  output logic                   out_valid,
  output logic [N_DATA_BITS-1:0] out_data,
  output logic [AW-1:0]          ram_addr1,
  input  logic [N_DATA_BITS-1:0] ram_rdata1,
  output logic                   ram_wen0,
  output logic [AW-1:0]          ram_addr0,
  output logic [NB-1:0]          ram_byteena0,
  output logic [N_DATA_BITS-1:0] ram_wdata0
);

  localparam int L = RAM_RD_LATENCY;

  // Handshake: a request transfers on any cycle with in_valid && in_ready;
  // responses are single-cycle out_valid pulses with no backpressure.
  logic                   w_accept;
  logic [L-1:0]           r_pipe_valid;
  t_rmw_op                r_pipe_op   [L];
  logic [AW-1:0]          r_pipe_addr [L];
  logic [NB-1:0]          r_pipe_be   [L];
  logic [N_DATA_BITS-1:0] r_pipe_data [L];

  logic                   w_c_valid;
  t_rmw_op                w_c_op;
  logic [AW-1:0]          w_c_addr;
  logic [NB-1:0]          w_c_be;
  logic [N_DATA_BITS-1:0] w_c_data;
  logic [N_DATA_BITS-1:0] w_old;
  logic [N_DATA_BITS-1:0] w_new;
  logic                   w_wen;

  logic                   r_out_valid;
  logic [N_DATA_BITS-1:0] r_out_data;

  assign in_ready  = ram_rdy && !reset;
  assign w_accept  = in_valid && in_ready;
  assign ram_addr1 = in_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_valid <= '0;
    end else begin
      for (int i = L - 1; i > 0; i--) r_pipe_valid[i] <= r_pipe_valid[i-1];
      r_pipe_valid[0] <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      r_pipe_op[i]   <= r_pipe_op[i-1];
      r_pipe_addr[i] <= r_pipe_addr[i-1];
      r_pipe_be[i]   <= r_pipe_be[i-1];
      r_pipe_data[i] <= r_pipe_data[i-1];
    end
    r_pipe_op[0]   <= t_rmw_op'(in_op);
    r_pipe_addr[0] <= in_addr;
    r_pipe_be[0]   <= in_byteena;
    r_pipe_data[0] <= in_data;
  end

  assign w_c_valid = r_pipe_valid[L-1];
  assign w_c_op    = r_pipe_op[L-1];
  assign w_c_addr  = r_pipe_addr[L-1];
  assign w_c_be    = r_pipe_be[L-1];
  assign w_c_data  = r_pipe_data[L-1];

  cci_mpf_prim_rmw_fwd_history #(
    .L  (L),
    .AW (AW),
    .NB (NB),
    .BB (N_BYTE_BITS)
  ) u_hist (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_push_valid   (w_wen),
    .i_push_addr    (w_c_addr),
    .i_push_byteena (w_c_be),
    .i_push_data    (w_new),
    .i_lookup_addr  (w_c_addr),
    .i_lookup_rdata (ram_rdata1),
    .o_patched_data (w_old)
  );

  always_comb begin
    w_new = w_old;
    for (int b = 0; b < NB; b++) begin
      if (w_c_be[b]) begin
        w_new[b*N_BYTE_BITS +: N_BYTE_BITS] = N_BYTE_BITS'(rmw_lane_apply(
          w_c_op,
          MAX_LANE_BITS'(w_old[b*N_BYTE_BITS +: N_BYTE_BITS]),
          MAX_LANE_BITS'(w_c_data[b*N_BYTE_BITS +: N_BYTE_BITS])));
      end
    end
  end

  // Reset also gates the commit so nothing lands while the pipe is being flushed.
  assign w_wen        = w_c_valid && !reset && (w_c_op != READ) && (|w_c_be);
  assign ram_wen0     = w_wen;
  assign ram_addr0    = w_c_addr;
  assign ram_byteena0 = w_c_be;
  assign ram_wdata0   = w_new;

  always_ff @(posedge clk) begin
    if (reset) r_out_valid <= 1'b0;
    else       r_out_valid <= w_c_valid;
    r_out_data <= w_old;
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_cci_mpf_prim_ram_rmw_pipe.sv
// Bench for the RMW pipeline with a behavioural RAM of read latency 2.
module tb_cci_mpf_prim_ram_rmw_pipe;
  import cci_mpf_prim_rmw_pkg::*;

  localparam int L = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        ram_rdy;
  logic        in_ready;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [4:0]  in_addr;
  logic [7:0]  in_byteena;
  logic [63:0] in_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic [4:0]  ram_addr1;
  logic [63:0] ram_rdata1;
  logic        ram_wen0;
  logic [4:0]  ram_addr0;
  logic [7:0]  ram_byteena0;
  logic [63:0] ram_wdata0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cci_mpf_prim_ram_rmw_pipe #(
    .N_ENTRIES(32), .N_DATA_BITS(64), .N_BYTE_BITS(8), .RAM_RD_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .ram_rdy(ram_rdy), .in_ready(in_ready),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_byteena(in_byteena), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .ram_addr1(ram_addr1), .ram_rdata1(ram_rdata1),
    .ram_wen0(ram_wen0), .ram_addr0(ram_addr0),
    .ram_byteena0(ram_byteena0), .ram_wdata0(ram_wdata0)
  );

  // RAM: one read register plus one output register.
  logic [63:0] ram_mem [32] = '{default: '0};
  logic [63:0] ram_r1, ram_r2;
  always @(posedge clk) begin
    if (ram_wen0) begin
      for (int b = 0; b < 8; b++)
        if (ram_byteena0[b]) ram_mem[ram_addr0][b*8 +: 8] <= ram_wdata0[b*8 +: 8];
    end
    ram_r1 <= ram_mem[ram_addr1];
    ram_r2 <= ram_r1;
  end
  assign ram_rdata1 = ram_r2;

  // ---------------- scoreboard ----------------
  int          n_chk = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] sb_mem [32] = '{default: '0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_apply(input t_rmw_op op, input logic [4:0] a,
                                              input logic [7:0] be, input logic [63:0] d);
    logic [63:0] o, n;
    o = sb_mem[a];
    n = o;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) begin
        case (op)
          WRITE:   n[b*8 +: 8] = d[b*8 +: 8];
          ADD:     n[b*8 +: 8] = o[b*8 +: 8] + d[b*8 +: 8];
          OR:      n[b*8 +: 8] = o[b*8 +: 8] | d[b*8 +: 8];
          default: n[b*8 +: 8] = o[b*8 +: 8];
        endcase
      end
    end
    sb_mem[a] = n;
    return o;
  endfunction

  always @(negedge clk) begin
    if (ram_wen0) n_wr++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_resp: got out_valid=1 data %h, expected no response (cycle %0d)",
                 out_data, cyc);
      end else begin
        check("resp_data", out_data, exp_q.pop_front());
        check("resp_latency", 64'(cyc), 64'(exp_cyc_q.pop_front() + L + 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input t_rmw_op op, input logic [4:0] a, input logic [7:0] be,
                       input logic [63:0] d, input logic [63:0] exp, input bit push);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    in_op      = op;
    in_addr    = a;
    in_byteena = be;
    in_data    = d;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 0;
    idle(1);
    while (exp_q.size() != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    idle(2);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    t_rmw_op     op;
    logic [4:0]  addr;
    logic [7:0]  be;
    logic [63:0] data;
    int          gap;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    logic [63:0] dummy;
    int          wr_start;

    tbl[0]  = '{WRITE, 5'd3, 8'hFF, 64'h1122334455667788, 0,  64'h0};
    tbl[1]  = '{READ,  5'd3, 8'h00, 64'h0,                10, 64'h1122334455667788};
    tbl[2]  = '{ADD,   5'd5, 8'h01, 64'h01,               2,  64'h00};
    tbl[3]  = '{ADD,   5'd5, 8'h01, 64'h01,               0,  64'h01};
    tbl[4]  = '{ADD,   5'd5, 8'h01, 64'h01,               0,  64'h02};
    tbl[5]  = '{ADD,   5'd5, 8'h01, 64'h01,               0,  64'h03};
    tbl[6]  = '{READ,  5'd5, 8'h00, 64'h0,                0,  64'h04};
    tbl[7]  = '{READ,  5'd5, 8'h00, 64'h0,                5,  64'h04};
    tbl[8]  = '{WRITE, 5'd7, 8'hFF, 64'h00000000000000FF, 0,  64'h0};
    tbl[9]  = '{ADD,   5'd7, 8'h01, 64'h02,               0,  64'h00000000000000FF};
    tbl[10] = '{READ,  5'd7, 8'h00, 64'h0,                0,  64'h0000000000000001};
    tbl[11] = '{WRITE, 5'd9, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 2,  64'h0};
    tbl[12] = '{OR,    5'd9, 8'hF0, 64'h5555555555555555, 0,  64'h00000000AAAAAAAA};
    tbl[13] = '{READ,  5'd9, 8'h00, 64'h0,                0,  64'h55555555AAAAAAAA};
    tbl[14] = '{WRITE, 5'd9, 8'h00, 64'hFFFFFFFFFFFFFFFF, 0,  64'h55555555AAAAAAAA};
    tbl[15] = '{READ,  5'd9, 8'h00, 64'h0,                0,  64'h55555555AAAAAAAA};

    reset = 1'b1; ram_rdy = 1'b0; in_valid = 1'b0;
    in_op = 2'd0; in_addr = '0; in_byteena = '0; in_data = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_wen", 64'(ram_wen0), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end

    // ram_rdy low: a request held valid must not be taken
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b1; in_op = WRITE; in_addr = 5'd0; in_byteena = 8'hFF; in_data = '1;
    repeat (4) begin
      @(negedge clk);
      check("rdy_low_in_ready", 64'(in_ready), 64'd0);
      check("rdy_low_wen", 64'(ram_wen0), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ram_rdy  = 1'b1;
    @(negedge clk);
    check("rdy_high_in_ready", 64'(in_ready), 64'd1);

    // Table phase
    wr_start = n_wr;
    for (int i = 0; i < NV; i++) begin
      idle(tbl[i].gap);
      dummy = model_apply(tbl[i].op, tbl[i].addr, tbl[i].be, tbl[i].data);
      issue(tbl[i].op, tbl[i].addr, tbl[i].be, tbl[i].data, tbl[i].exp, 1'b1);
    end
    drain();
    check("tbl_write_count", 64'(n_wr - wr_start), 64'd9);

    // Random phase on a few hot addresses
    for (int i = 0; i < 60; i++) begin
      t_rmw_op     op;
      logic [4:0]  a;
      logic [7:0]  be;
      logic [63:0] d;
      op = t_rmw_op'($urandom_range(0, 3));
      a  = 5'(16 + $urandom_range(0, 3));
      be = 8'($urandom_range(0, 255));
      d  = {$urandom, $urandom};
      issue(op, a, be, d, model_apply(op, a, be, d), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    // Reset while two ADDs are in flight
    issue(WRITE, 5'd20, 8'hFF, 64'h10, model_apply(WRITE, 5'd20, 8'hFF, 64'h10), 1'b1);
    drain();
    issue(ADD, 5'd20, 8'hFF, 64'h0101010101010101, 64'h0, 1'b0);
    issue(ADD, 5'd20, 8'hFF, 64'h0101010101010101, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_wen", 64'(ram_wen0), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("postrst_wen", 64'(ram_wen0), 64'd0);
      check("postrst_out_valid", 64'(out_valid), 64'd0);
    end
    issue(READ, 5'd20, 8'h00, 64'h0, model_apply(READ, 5'd20, 8'h00, 64'h0), 1'b1);
    drain();
    check("postrst_mem20", ram_mem[20], 64'h10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
